// File: rtl/uart_send_param.sv
// Parametrised UART transmitter: 5-9 data bits, optional odd/even parity, 1-2 stop bits.
// A small FIFO behind a ready/valid handshake lets queued words leave back-to-back.
module uart_send_param #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          valid,
  input  logic [DATA_BITS-1:0]          data,
  output logic                          ready,
  output logic                          dout,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int BIT_CYCLES = CLK_FREQ / BAUD_RATE;
  localparam int CW         = $clog2(BIT_CYCLES + 1);
  localparam int AW         = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] BAUD_LAST  = CW'(BIT_CYCLES - 1);
  localparam logic [AW:0]   LEVEL_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [3:0]    DATA_LAST  = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST  = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t                 r_state;
  state_t                 w_nextState;
  logic [DATA_BITS-1:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0]          r_wrPtr;
  logic [AW-1:0]          r_rdPtr;
  logic [AW:0]            r_level;
  logic [CW-1:0]          r_baudCnt;
  logic [3:0]             r_bitCnt;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_parity;
  logic                   r_dout;
  logic                   r_lineBusy;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_bitDone;
  logic                   w_fifoEmpty;

  assign w_fifoEmpty = (r_level == '0);
  assign ready       = (r_level != LEVEL_FULL);
  assign w_push      = valid && ready;
  assign w_bitDone   = (r_baudCnt == BAUD_LAST);
  assign fifo_level  = r_level;
  assign dout        = r_dout;
  // dout lags the FSM by one clock, so r_lineBusy keeps busy high until the last stop bit leaves the pin.
  assign busy        = !w_fifoEmpty || (r_state != IDLE) || r_lineBusy;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wrPtr] <= data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // STOP chains straight into START when another word is waiting, leaving no idle gap.
  always_comb begin
    w_nextState = r_state;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_fifoEmpty) begin
          w_nextState = START;
          w_pop       = 1'b1;
        end
      end
      START: begin
        if (w_bitDone) w_nextState = DATA;
      end
      DATA: begin
        if (w_bitDone && (r_bitCnt == DATA_LAST)) w_nextState = (PARITY != 0) ? PAR : STOP;
      end
      PAR: begin
        if (w_bitDone) w_nextState = STOP;
      end
      STOP: begin
        if (w_bitDone && (r_bitCnt == STOP_LAST)) begin
          if (!w_fifoEmpty) begin
            w_nextState = START;
            w_pop       = 1'b1;
          end else begin
            w_nextState = IDLE;
          end
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_baudCnt <= '0;
      r_bitCnt  <= '0;
    end else begin
      r_state   <= w_nextState;
      r_baudCnt <= ((r_state == IDLE) || w_bitDone) ? '0 : r_baudCnt + 1'b1;
      if (w_nextState != r_state) r_bitCnt <= '0;
      else if (w_bitDone)         r_bitCnt <= r_bitCnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift  <= '0;
      r_parity <= 1'b0;
    end else if (w_pop) begin
      r_shift  <= r_mem[r_rdPtr];
      r_parity <= (^r_mem[r_rdPtr]) ^ (PARITY == 1);
    end else if ((r_state == DATA) && w_bitDone) begin
      r_shift  <= r_shift >> 1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dout     <= 1'b1;
      r_lineBusy <= 1'b0;
    end else begin
      r_lineBusy <= (r_state != IDLE);
      case (r_state)
        START:   r_dout <= 1'b0;
        DATA:    r_dout <= r_shift[0];
        PAR:     r_dout <= r_parity;
        default: r_dout <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_send_param.sv
// Bench for uart_send_param: three instances (8N1, 7E2, 7O2) checked every cycle against a frame-timeline model.
// Directed literal checks pin the model: known frames, handshake limits, async reset, push/pop on the same edge.
module tb_uart_send_param;

  localparam int BCM [3] = '{16, 8, 8};
  localparam int DBM [3] = '{8, 7, 7};
  localparam int PRM [3] = '{0, 2, 1};
  localparam int SBM [3] = '{1, 2, 2};

  typedef struct {
    int         inst;
    logic [8:0] w;
  } entry_t;

  logic       clk;
  logic       rst;
  logic       valid  [3];
  logic [8:0] din    [3];
  logic       doutW  [3];
  logic       readyW [3];
  logic       busyW  [3];
  logic [2:0] levelW [3];

  int errors = 0;
  int checks = 0;

  entry_t     mq [$];
  bit         mActive     [3];
  bit         mPrevActive [3];
  int         mCyc        [3];
  logic [8:0] mWord       [3];
  logic       expDout     [3];
  logic       expReady    [3];
  logic       expBusy     [3];
  int         expLevel    [3];

  logic expA5   [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
  logic expEven [11] = '{0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 1};
  logic expOdd  [11] = '{0, 0, 0, 1, 1, 1, 1, 0, 1, 1, 1};

  uart_send_param #(.CLK_FREQ(100), .BAUD_RATE(6), .DATA_BITS(8), .PARITY(0),
                    .STOP_BITS(1), .FIFO_DEPTH(4)) dut0 (
    .clk(clk), .rst(rst), .valid(valid[0]), .data(din[0][7:0]),
    .ready(readyW[0]), .dout(doutW[0]), .busy(busyW[0]), .fifo_level(levelW[0]));

  uart_send_param #(.CLK_FREQ(8), .BAUD_RATE(1), .DATA_BITS(7), .PARITY(2),
                    .STOP_BITS(2), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .rst(rst), .valid(valid[1]), .data(din[1][6:0]),
    .ready(readyW[1]), .dout(doutW[1]), .busy(busyW[1]), .fifo_level(levelW[1]));

  uart_send_param #(.CLK_FREQ(8), .BAUD_RATE(1), .DATA_BITS(7), .PARITY(1),
                    .STOP_BITS(2), .FIFO_DEPTH(4)) dut2 (
    .clk(clk), .rst(rst), .valid(valid[2]), .data(din[2][6:0]),
    .ready(readyW[2]), .dout(doutW[2]), .busy(busyW[2]), .fifo_level(levelW[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int frameLen(int i);
    return 1 + DBM[i] + ((PRM[i] != 0) ? 1 : 0) + SBM[i];
  endfunction

  // Line value for bit slot k of a frame: start, data LSB first, optional parity, stop bits.
  function automatic logic frameBit(int i, logic [8:0] w, int k);
    logic par;
    par = 1'b0;
    if (k == 0) return 1'b0;
    if (k <= DBM[i]) return w[k-1];
    if ((PRM[i] != 0) && (k == DBM[i] + 1)) begin
      for (int j = 0; j < DBM[i]; j++) par = par ^ w[j];
      return (PRM[i] == 2) ? par : ~par;
    end
    return 1'b1;
  endfunction

  function automatic int countOf(int i);
    int n;
    n = 0;
    foreach (mq[j]) if (mq[j].inst == i) n++;
    return n;
  endfunction

  function automatic logic [8:0] popFor(int i);
    logic [8:0] w;
    w = '0;
    for (int j = 0; j < mq.size(); j++) begin
      if (mq[j].inst == i) begin
        w = mq[j].w;
        mq.delete(j);
        break;
      end
    end
    return w;
  endfunction

  // Model: each instance is a FIFO of accepted words plus a frame timeline measured in clocks.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      for (int i = 0; i < 3; i++) begin
        mActive[i]     = 1'b0;
        mPrevActive[i] = 1'b0;
        mCyc[i]        = 0;
        mWord[i]       = '0;
        expDout[i]     = 1'b1;
        expReady[i]    = 1'b1;
        expBusy[i]     = 1'b0;
        expLevel[i]    = 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        int     n;
        bit     doPush;
        bit     frameEnd;
        bit     doPop;
        entry_t e;
        n        = countOf(i);
        doPush   = valid[i] && (n < 4);
        frameEnd = mActive[i] && (mCyc[i] == frameLen(i) * BCM[i] - 1);
        doPop    = (n > 0) && (!mActive[i] || frameEnd);
        expDout[i]     = mActive[i] ? frameBit(i, mWord[i], mCyc[i] / BCM[i]) : 1'b1;
        mPrevActive[i] = mActive[i];
        if (doPop) begin
          mWord[i]   = popFor(i);
          mActive[i] = 1'b1;
          mCyc[i]    = 0;
        end else if (frameEnd) begin
          mActive[i] = 1'b0;
        end else if (mActive[i]) begin
          mCyc[i]    = mCyc[i] + 1;
        end
        if (doPush) begin
          e.inst = i;
          e.w    = din[i];
          mq.push_back(e);
        end
        expLevel[i] = countOf(i);
        expReady[i] = (expLevel[i] < 4);
        expBusy[i]  = (expLevel[i] > 0) || mActive[i] || mPrevActive[i];
      end
    end
  end

  task automatic checkOutput(input string name, input int inst, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s[%0d] at %0t: got %0h expected %0h", name, inst, $time, act, exp);
    end
  endtask

  // Every cycle, on the falling edge, all outputs of every instance are held against the model.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      checkOutput("dout", i, 32'(doutW[i]), 32'(expDout[i]));
      checkOutput("ready", i, 32'(readyW[i]), 32'(expReady[i]));
      checkOutput("busy", i, 32'(busyW[i]), 32'(expBusy[i]));
      checkOutput("fifo_level", i, 32'(levelW[i]), 32'(expLevel[i]));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents one word per selected instance for exactly one rising edge.
  task automatic applyStimulus(input bit [2:0] mask, input logic [8:0] w0,
                               input logic [8:0] w1, input logic [8:0] w2);
    din[0] = w0;
    din[1] = w1;
    din[2] = w2;
    for (int i = 0; i < 3; i++) begin
      if (mask[i]) begin
        checkOutput("ready before push", i, 32'(readyW[i]), 32'd1);
        valid[i] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) valid[i] = 1'b0;
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int accepts;
    int n;
    bit r;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      valid[i] = 1'b0;
      din[i]   = '0;
    end
    tick(3);
    checkOutput("reset dout", 0, 32'(doutW[0]), 32'd1);
    checkOutput("reset ready", 0, 32'(readyW[0]), 32'd1);
    checkOutput("reset busy", 0, 32'(busyW[0]), 32'd0);
    checkOutput("reset level", 0, 32'(levelW[0]), 32'd0);
    rst = 1'b1;
    tick(2);

    $display("[TB] single 8'hA5 frame");
    applyStimulus(3'b001, 9'hA5, 9'h0, 9'h0);
    checkOutput("level after push", 0, 32'(levelW[0]), 32'd1);
    checkOutput("busy after push", 0, 32'(busyW[0]), 32'd1);
    for (int k = 0; k < 10; k++) begin
      tick((k == 0) ? 10 : 16);
      checkOutput("A5 bit", k, 32'(doutW[0]), 32'(expA5[k]));
    end
    tick(7);
    checkOutput("busy before frame end", 0, 32'(busyW[0]), 32'd1);
    tick(1);
    checkOutput("busy at frame end", 0, 32'(busyW[0]), 32'd0);

    $display("[TB] 7-bit 3C with even and odd parity, two stop bits");
    applyStimulus(3'b110, 9'h0, 9'h3C, 9'h3C);
    for (int k = 0; k < 11; k++) begin
      tick((k == 0) ? 6 : 8);
      checkOutput("even frame bit", k, 32'(doutW[1]), 32'(expEven[k]));
      checkOutput("odd frame bit", k, 32'(doutW[2]), 32'(expOdd[k]));
    end
    tick(10);
    checkOutput("even busy done", 1, 32'(busyW[1]), 32'd0);
    checkOutput("odd busy done", 2, 32'(busyW[2]), 32'd0);

    $display("[TB] streaming with valid held");
    accepts  = 0;
    n        = 0;
    din[0]   = 9'h01;
    valid[0] = 1'b1;
    while (readyW[0] && (n < 20)) begin
      r = readyW[0];
      tick(1);
      n++;
      if (r) begin
        accepts++;
        din[0] = din[0] + 9'h1;
      end
    end
    checkOutput("stream accepts", 0, 32'(accepts), 32'd5);
    checkOutput("stream level full", 0, 32'(levelW[0]), 32'd4);
    checkOutput("stream ready low", 0, 32'(readyW[0]), 32'd0);
    for (int c = 0; c < 5; c++) begin
      tick(1);
      checkOutput("level while full", 0, 32'(levelW[0]), 32'd4);
    end
    valid[0] = 1'b0;
    n = 0;
    while (busyW[0] && (n < 1000)) begin
      tick(1);
      n++;
    end
    checkOutput("stream drained", 0, 32'(busyW[0]), 32'd0);

    $display("[TB] async reset in the middle of a frame");
    applyStimulus(3'b011, 9'hFF, 9'h00, 9'h0);
    applyStimulus(3'b001, 9'h12, 9'h0, 9'h0);
    applyStimulus(3'b001, 9'h34, 9'h0, 9'h0);
    tick(40);
    checkOutput("queued before reset", 0, 32'(levelW[0]), 32'd2);
    checkOutput("FF data bit before reset", 0, 32'(doutW[0]), 32'd1);
    checkOutput("zero data bit before reset", 1, 32'(doutW[1]), 32'd0);
    #2 rst = 1'b0;
    #1;
    checkOutput("dout after reset", 0, 32'(doutW[0]), 32'd1);
    checkOutput("dout after reset", 1, 32'(doutW[1]), 32'd1);
    checkOutput("level after reset", 0, 32'(levelW[0]), 32'd0);
    checkOutput("busy after reset", 0, 32'(busyW[0]), 32'd0);
    checkOutput("ready after reset", 0, 32'(readyW[0]), 32'd1);
    tick(3);
    rst = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick(1);
      checkOutput("line idle after reset", 0, 32'(doutW[0]), 32'd1);
      checkOutput("line idle after reset", 1, 32'(doutW[1]), 32'd1);
    end

    $display("[TB] push on the same edge as the final stop clock");
    applyStimulus(3'b001, 9'h5A, 9'h0, 9'h0);
    tick(19);
    applyStimulus(3'b001, 9'h00, 9'h0, 9'h0);
    checkOutput("level mid frame", 0, 32'(levelW[0]), 32'd1);
    tick(140);
    checkOutput("level before swap", 0, 32'(levelW[0]), 32'd1);
    applyStimulus(3'b001, 9'hFF, 9'h0, 9'h0);
    checkOutput("level after push and pop", 0, 32'(levelW[0]), 32'd1);
    tick(8);
    checkOutput("next start bit", 0, 32'(doutW[0]), 32'd0);
    tick(160);
    checkOutput("level after last pop", 0, 32'(levelW[0]), 32'd0);
    n = 0;
    while (busyW[0] && (n < 400)) begin
      tick(1);
      n++;
    end
    checkOutput("final drain", 0, 32'(busyW[0]), 32'd0);
    tick(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
